serial_add_sub_unit: RTL and testbench
======================================

SERIAL_ADD_SUB_UNIT -- requirements
Module: serial_add_sub_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk (rising edge), rst_n (asserted low).
REQ-002 Parameters SHALL be:
  - WIDTH, 8, operand/result width in bits, >= 2.
  - DIGIT, 1, bits processed per cycle; WIDTH % DIGIT != 0 SHALL be an elaboration error.
REQ-003 Ports SHALL be:
  - clk        in   1      clock
  - rst_n      in   1      async active-low reset
  - in_valid   in   1      operands/op presented
  - in_ready   out  1      block accepts operands
  - op         in   2      00 ADD a+b; 01 SUB a-b; 10 ADC a+b+cin; 11 SBB a-b-cin
  - cin        in   1      carry/borrow in, used by ADC/SBB only
  - a          in   WIDTH  operand A
  - b          in   WIDTH  operand B
  - out_valid  out  1      result presented
  - out_ready  in   1      consumer accepts result
  - result     out  WIDTH  sum/difference
  - cout       out  1      raw carry out of MSB (SUB/SBB: 1 = no borrow)
  - ovf        out  1      two's-complement overflow
  - zero       out  1      result == 0
  - neg        out  1      result[WIDTH-1]

Function
REQ-004 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-005 in_ready SHALL be 1 in IDLE only; out_valid SHALL be 1 in DONE only, both driven from state.
REQ-006 IDLE: on a clock edge with in_valid=1, the block SHALL capture a, b, op and cin, load digit counter = 0, and go to RUN; with in_valid=0 it SHALL stay in IDLE.
REQ-007 Operand B SHALL be inverted at capture for SUB/SBB.
REQ-008 Initial carry SHALL be:
  - ADD: 0
  - SUB: 1
  - ADC: cin
  - SBB: ~cin
REQ-009 RUN: each edge SHALL add the low DIGIT bits of the A/B shift registers plus the carry, shift the DIGIT sum bits into result from the MSB end, shift A/B right by DIGIT, update the carry, and increment the counter.
REQ-010 After the N-th RUN edge (N = WIDTH/DIGIT) the block SHALL enter DONE, so out_valid rises exactly N cycles after the accepting edge.
REQ-011 ovf SHALL equal carry-into-MSB XOR carry-out-of-MSB, taken inside the final digit.
REQ-012 cout, ovf, zero and neg SHALL be registered on entry to DONE.
REQ-013 DONE: result and all flags SHALL hold stable until an edge with out_ready=1, which SHALL return the block to IDLE; out_ready low SHALL stall indefinitely.
REQ-014 in_valid SHALL be ignored in RUN and DONE, with no queueing; no new operand is accepted on the out_ready edge; minimum issue interval is N+2 cycles.
REQ-015 result and flags SHALL keep their last DONE values while in IDLE/RUN; only out_valid qualifies them.
REQ-016 Arithmetic SHALL be modulo 2^WIDTH; there SHALL be no saturation.
REQ-017 in_valid and out_ready outside their states SHALL have no effect.

Reset
REQ-018 While rst_n=0, state SHALL be IDLE, and result, cout, ovf, zero, neg, out_valid, the counter, the carry and the shift registers SHALL be 0, regardless of clk.
REQ-019 in_ready SHALL read 1 during reset; no capture SHALL occur while rst_n=0.
REQ-020 Reset asserted mid-RUN or mid-DONE SHALL abandon the operation with no partial result visible.
REQ-021 The first edge after rst_n rises SHALL behave as IDLE.

Verification
REQ-022 WIDTH=8, DIGIT=1, ADD 0x7F+0x01 -> out_valid exactly 8 cycles after accept; result=0x80, cout=0, ovf=1, neg=1, zero=0.
REQ-023 SUB 0x05-0x05 -> result=0x00, cout=1, zero=1, ovf=0; SUB 0x00-0x01 -> result=0xFF, cout=0, neg=1, ovf=0.
REQ-024 ADC 0xFF+0x00, cin=1 -> result=0x00, cout=1, zero=1; SBB 0x10-0x01, cin=1 -> result=0x0E, cout=1; SBB 0x80-0x01, cin=0 -> result=0x7F, ovf=1.
REQ-025 Hold out_ready=0 for 5 cycles in DONE while toggling in_valid and operands -> result/flags unchanged, in_ready=0, no capture; out_ready=1 -> IDLE next cycle.
REQ-026 Assert rst_n=0 on the 3rd RUN cycle -> all outputs 0 immediately (asynchronously); release, then issue ADD 0x03+0x04 -> result=0x07 after 8 cycles.
REQ-027 WIDTH=16, DIGIT=4, ADD 0xFFFF+0x0001 -> out_valid 4 cycles after accept; result=0x0000, cout=1, zero=1, ovf=0.

Source files
------------

// File: rtl/serial_add_sub_unit.sv
// Serial add/subtract unit: DIGIT bits per cycle, WIDTH/DIGIT cycles per op.
// Valid/ready handshake on both sides; one operation in flight at a time.
module serial_add_sub_unit #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_add_sub_unit: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   dsum;
  logic             c_msb;
  logic             last;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // One digit of ripple add; carry into the digit MSB recovered from the sum bit.
  always_comb begin
    dsum    = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    c_msb   = a_sr[DIGIT-1] ^ b_sr[DIGIT-1] ^ dsum[DIGIT-1];
    res_nxt = WIDTH'({dsum[DIGIT-1:0], res_sr} >> DIGIT);
    last    = (cnt == CW'(N - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: accept in IDLE, N digit steps in RUN, hold in DONE until drained.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, digit shifting, and result/flag registers loaded on DONE entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
      neg    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sr  <= a;
          // Subtraction as a + ~b + 1; the +1 (or borrow) rides in the initial carry.
          b_sr  <= op[0] ? ~b : b;
          carry <= op[1] ? (op[0] ? ~cin : cin) : op[0];
          cnt   <= '0;
        end
        RUN: begin
          a_sr   <= a_sr >> DIGIT;
          b_sr   <= b_sr >> DIGIT;
          res_sr <= res_nxt;
          carry  <= dsum[DIGIT];
          cnt    <= cnt + 1'b1;
          if (last) begin
            result <= res_nxt;
            cout   <= dsum[DIGIT];
            ovf    <= c_msb ^ dsum[DIGIT];
            zero   <= (res_nxt == '0);
            neg    <= res_nxt[WIDTH-1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub_unit.sv
// Directed bench for serial_add_sub_unit: 8-bit/1-digit and 16-bit/4-digit instances.
module tb_serial_add_sub_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 8-bit, 1 bit per cycle
  logic       rst_n, in_valid, in_ready, cin, out_valid, out_ready, cout, ovf, zero, neg;
  logic [1:0] op;
  logic [7:0] a, b, result;

  serial_add_sub_unit #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .cin(cin),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
  );

  // 16-bit, 4 bits per cycle
  logic        rst16_n, iv16, ir16, cin16, ov16, or16, cout16, ovf16, zero16, neg16;
  logic [1:0]  op16;
  logic [15:0] a16, b16, res16;

  serial_add_sub_unit #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst_n(rst16_n), .in_valid(iv16), .in_ready(ir16), .op(op16), .cin(cin16),
    .a(a16), .b(b16), .out_valid(ov16), .out_ready(or16), .result(res16),
    .cout(cout16), .ovf(ovf16), .zero(zero16), .neg(neg16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one 8-bit op, verify exact latency and result/flags, optionally drain.
  task automatic run8(input string tag, input logic [1:0] o, input logic c,
                      input logic [7:0] x, input logic [7:0] y, input logic [7:0] er,
                      input logic ec, input logic eo, input logic ez, input logic en,
                      input logic drain);
    op = o; cin = c; a = x; b = y; in_valid = 1'b1;
    chk({tag, " in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, " busy"}, in_ready, 0);
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (i < 8) chk({tag, " early"}, out_valid, 0);
      else       chk({tag, " out_valid"}, out_valid, 1);
    end
    chk({tag, " result"}, result, er);
    chk({tag, " cout"}, cout, ec);
    chk({tag, " ovf"}, ovf, eo);
    chk({tag, " zero"}, zero, ez);
    chk({tag, " neg"}, neg, en);
    if (drain) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, " drained"}, {out_valid, in_ready}, 2'b01);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = 2'b00; cin = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    rst16_n = 1'b0; iv16 = 1'b0; op16 = 2'b00; cin16 = 1'b0; a16 = '0; b16 = '0; or16 = 1'b0;
    #1;
    chk("rst outs", {result, cout, ovf, zero, neg, out_valid}, '0);
    chk("rst in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1; rst16_n = 1'b1;

    run8("add7f01", 2'b00, 1'b0, 8'h7F, 8'h01, 8'h80, 0, 1, 0, 1, 1);
    run8("sub0505", 2'b01, 1'b0, 8'h05, 8'h05, 8'h00, 1, 0, 1, 0, 1);
    run8("sub0001", 2'b01, 1'b0, 8'h00, 8'h01, 8'hFF, 0, 0, 0, 1, 1);
    run8("adcff00", 2'b10, 1'b1, 8'hFF, 8'h00, 8'h00, 1, 0, 1, 0, 1);
    run8("sbb1001", 2'b11, 1'b1, 8'h10, 8'h01, 8'h0E, 1, 0, 0, 0, 1);
    run8("sbb8001", 2'b11, 1'b0, 8'h80, 8'h01, 8'h7F, 1, 1, 0, 0, 1);
    // cin must be ignored for plain ADD
    run8("addcin", 2'b00, 1'b1, 8'h12, 8'h34, 8'h46, 0, 0, 0, 0, 0);

    // Stall in DONE while inputs wiggle.
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid; a = 8'(i * 37); b = 8'(i * 91); op = 2'(i);
      @(posedge clk); #1;
      chk("stall result", result, 8'h46);
      chk("stall flags", {cout, ovf, zero, neg}, 4'b0000);
      chk("stall hs", {out_valid, in_ready}, 2'b10);
    end
    // in_valid high on the draining edge must not be taken.
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("release hs", {out_valid, in_ready}, 2'b01);
    chk("idle hold", result, 8'h46);
    @(posedge clk); #1;
    chk("no capture", in_ready, 1);

    // Async reset in the 3rd RUN cycle.
    op = 2'b00; a = 8'h55; b = 8'h22; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("run hold", result, 8'h46);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid rst outs", {result, cout, ovf, zero, neg, out_valid}, '0);
    chk("mid rst in_ready", in_ready, 1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("rst no cap", {in_ready, out_valid, result}, {2'b10, 8'h00});
    rst_n = 1'b1; in_valid = 1'b0;
    run8("add0304", 2'b00, 1'b0, 8'h03, 8'h04, 8'h07, 0, 0, 0, 0, 1);

    // 16-bit, 4 digits per cycle.
    op16 = 2'b00; a16 = 16'hFFFF; b16 = 16'h0001; iv16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (i < 4) chk("w16 early", ov16, 0);
      else       chk("w16 out_valid", ov16, 1);
    end
    chk("w16 result", res16, 16'h0000);
    chk("w16 flags", {cout16, ovf16, zero16, neg16}, 4'b1010);
    or16 = 1'b1;
    @(posedge clk); #1;
    or16 = 1'b0;
    chk("w16 drained", {ov16, ir16}, 2'b01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
